// File: rtl/enet_nios_rx_pkg.sv
// ---------------------------------------------------------------------------
// enet_nios_rx_pkg
// Shared definitions for the Ethernet receive frame-length accounting stage:
//   - FSM state encoding (IDLE / COUNT)
//   - default counter width and runt / giant thresholds
//   - bit positions of the result word as laid out in the Nios-visible
//     receive status register
// ---------------------------------------------------------------------------
package enet_nios_rx_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } rx_state_t;

   localparam int DEF_CNT_W   = 11;
   localparam int DEF_MIN_LEN = 64;
   localparam int DEF_MAX_LEN = 1518;

   // Host register map of the receive status word.
   localparam int RES_LEN_LSB   = 0;
   localparam int RES_RUNT_BIT  = 16;
   localparam int RES_GIANT_BIT = 17;
   localparam int RES_ERR_BIT   = 18;
   localparam int RES_OVR_BIT   = 30;
   localparam int RES_VALID_BIT = 31;

endpackage

// File: rtl/enet_nios_len_cnt.sv
// ---------------------------------------------------------------------------
// enet_nios_len_cnt
// Loadable saturating up-counter shaped like the counter-mode logic cell
// (sclr over sload over ena) so synthesis can map it onto the carry chain.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, q -> 0
//   sload  in   load q from data
//   sclr   in   clear q to 0 (wins over sload)
//   ena    in   count enable; increments unless already saturated
//   data   in   W  load value
//   q      out  W  counter value
//   sat    out  q is at its all-ones maximum
// ---------------------------------------------------------------------------
module enet_nios_len_cnt #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sload,
   input  logic         sclr,
   input  logic         ena,
   input  logic [W-1:0] data,
   output logic [W-1:0] q,
   output logic         sat
);

   logic [W-1:0] q_reg;

   assign q   = q_reg;
   assign sat = &q_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= '0;
      end else if (sclr) begin
         q_reg <= '0;
      end else if (sload) begin
         q_reg <= data;
      end else if (ena && !sat) begin
         q_reg <= q_reg + W'(1);
      end
   end

endmodule

// File: rtl/enet_nios_rx_len_counter.sv
// ---------------------------------------------------------------------------
// enet_nios_rx_len_counter
// Counts the bytes of each received Ethernet frame, classifies it as runt /
// giant / errored, and posts the result to the Nios host over a valid/ack
// handshake. A sticky overrun flag records results lost because the host had
// not yet consumed the previous one.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   rx_valid   in   byte strobe, one byte per asserted cycle
//   rx_sof     in   first byte of frame (qualified by rx_valid)
//   rx_eof     in   last byte of frame (qualified by rx_valid)
//   rx_err     in   MAC error on this byte (qualified by rx_valid)
//   res_valid  out  result word available
//   res_ack    in   host consumes result
//   res_len    out  CNT_W frame length in bytes
//   res_runt   out  length below MIN_LEN
//   res_giant  out  length above MAX_LEN or counter saturated
//   res_err    out  MAC error seen, or frame cut short by an early SOF
//   ovr        out  sticky overrun flag
//   ovr_clr    in   clears ovr
//   busy       out  high while a frame is being counted
// ---------------------------------------------------------------------------
module enet_nios_rx_len_counter
   import enet_nios_rx_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MIN_LEN = DEF_MIN_LEN,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_err,
   output logic             res_valid,
   input  logic             res_ack,
   output logic [CNT_W-1:0] res_len,
   output logic             res_runt,
   output logic             res_giant,
   output logic             res_err,
   output logic             ovr,
   input  logic             ovr_clr,
   output logic             busy
);

   // Giant detection relies on the saturated value being strictly above
   // MAX_LEN, otherwise a saturated count could look like a legal length.
   if (MAX_LEN >= (2**CNT_W) - 1) begin : g_bad_max_len
      $error("MAX_LEN must be below the counter saturation value");
   end

   localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   rx_state_t        state_reg, state_next;
   logic             pend_reg, pend_next;   // EOF byte absorbed, complete next cycle
   logic             err_reg, err_next;     // accumulated error of the open frame

   logic             cnt_sload, cnt_sclr, cnt_ena, cnt_sat;
   logic [CNT_W-1:0] cnt_q;

   logic             comp_fire;
   logic             comp_err;

   enet_nios_len_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .sload (cnt_sload),
      .sclr  (cnt_sclr),
      .ena   (cnt_ena),
      .data  (ONE),
      .q     (cnt_q),
      .sat   (cnt_sat)
   );

   // Completions always read the counter register itself. An EOF byte is
   // counted first and completes on the following cycle (pend_reg); an
   // early SOF completes the running frame in its own cycle. Because an EOF
   // always leaves the FSM in IDLE, an early SOF can never coincide with a
   // pending EOF completion, so at most one completion fires per cycle.
   always_comb begin
      state_next = state_reg;
      pend_next  = 1'b0;
      err_next   = err_reg;
      cnt_sload  = 1'b0;
      cnt_ena    = 1'b0;
      comp_fire  = pend_reg;
      comp_err   = err_reg;

      case (state_reg)
         IDLE: begin
            if (rx_valid && rx_sof) begin
               cnt_sload = 1'b1;
               err_next  = rx_err;
               if (rx_eof) begin
                  pend_next = 1'b1;
               end else begin
                  state_next = COUNT;
               end
            end
         end
         COUNT: begin
            if (rx_valid) begin
               if (rx_sof) begin
                  // Early SOF: close the old frame as errored, restart at 1.
                  comp_fire = 1'b1;
                  comp_err  = 1'b1;
                  cnt_sload = 1'b1;
                  err_next  = rx_err;
               end else begin
                  cnt_ena  = 1'b1;
                  err_next = err_reg | rx_err;
               end
               if (rx_eof) begin
                  pend_next  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Clear the counter once its final value has been reported, unless a
      // new frame is loading in the same cycle.
      cnt_sclr = pend_reg && !cnt_sload;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         pend_reg  <= 1'b0;
         err_reg   <= 1'b0;
         res_valid <= 1'b0;
         res_len   <= '0;
         res_runt  <= 1'b0;
         res_giant <= 1'b0;
         res_err   <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         err_reg   <= err_next;

         if (comp_fire && (!res_valid || res_ack)) begin
            res_valid <= 1'b1;
            res_len   <= cnt_q;
            res_runt  <= (cnt_q < MIN_L);
            res_giant <= (cnt_q > MAX_L) || cnt_sat;
            res_err   <= comp_err;
         end else if (res_ack) begin
            res_valid <= 1'b0;
         end

         // A new overrun takes precedence over a clear in the same cycle.
         if (comp_fire && res_valid && !res_ack) begin
            ovr <= 1'b1;
         end else if (ovr_clr) begin
            ovr <= 1'b0;
         end
      end
   end

   assign busy = (state_reg == COUNT);

endmodule

// File: tb/tb_enet_nios_rx_len_counter.sv
// ---------------------------------------------------------------------------
// tb_enet_nios_rx_len_counter
// Directed bench for the receive frame-length accounting stage. Inputs change
// 1 ns after the rising edge; outputs are checked in the same window.
// ---------------------------------------------------------------------------
module tb_enet_nios_rx_len_counter;

   localparam int CNT_W = 11;

   logic             clk = 1'b0;
   logic             reset;
   logic             rx_valid, rx_sof, rx_eof, rx_err;
   logic             res_valid, res_ack;
   logic [CNT_W-1:0] res_len;
   logic             res_runt, res_giant, res_err;
   logic             ovr, ovr_clr, busy;

   int               total  = 0;
   int               passed = 0;

   always #5 clk = ~clk;

   enet_nios_rx_len_counter #(.CNT_W(CNT_W), .MIN_LEN(64), .MAX_LEN(1518)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_sof    (rx_sof),
      .rx_eof    (rx_eof),
      .rx_err    (rx_err),
      .res_valid (res_valid),
      .res_ack   (res_ack),
      .res_len   (res_len),
      .res_runt  (res_runt),
      .res_giant (res_giant),
      .res_err   (res_err),
      .ovr       (ovr),
      .ovr_clr   (ovr_clr),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sof, input bit eof, input bit err);
      rx_valid = 1'b1;
      rx_sof   = sof;
      rx_eof   = eof;
      rx_err   = err;
      step();
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rx_err   = 1'b0;
   endtask

   // Whole frame of n bytes; errpos selects the errored byte (0 = none).
   task automatic frame(input int n, input int errpos);
      for (int i = 1; i <= n; i++) begin
         send(i == 1, i == n, i == errpos);
      end
   endtask

   task automatic ack();
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rx_err   = 1'b0;
      res_ack  = 1'b0;
      ovr_clr  = 1'b0;
      step();
      step();
      chk("rst_valid", res_valid, 0);
      chk("rst_len",   res_len,   0);
      chk("rst_flags", {res_runt, res_giant, res_err}, 0);
      chk("rst_ovr",   ovr,       0);
      chk("rst_busy",  busy,      0);
      reset = 1'b0;
      step();

      // 64-byte clean frame
      send(1'b1, 1'b0, 1'b0);
      chk("f64_busy", busy, 1);
      for (int i = 2; i <= 64; i++) send(1'b0, i == 64, 1'b0);
      chk("f64_idle", busy, 0);
      chk("f64_notyet", res_valid, 0);
      step();
      chk("f64_valid", res_valid, 1);
      chk("f64_len",   res_len,   64);
      chk("f64_flags", {res_runt, res_giant, res_err}, 3'b000);
      ack();
      chk("f64_acked", res_valid, 0);
      $display("txn f64: len=%0d", 64);

      // 10-byte frame, error on byte 5
      frame(10, 5);
      step();
      chk("f10_len",   res_len, 10);
      chk("f10_flags", {res_runt, res_giant, res_err}, 3'b101);
      ack();
      $display("txn f10: len=%0d err=1", 10);

      // one-byte frame (SOF and EOF together)
      frame(1, 0);
      step();
      chk("f1_len",   res_len, 1);
      chk("f1_flags", {res_valid, res_runt, res_giant, res_err}, 4'b1100);
      ack();
      $display("txn f1: len=1");

      // 2100-byte frame saturates at 2047
      frame(2100, 0);
      step();
      chk("f2100_len",   res_len, 2047);
      chk("f2100_flags", {res_runt, res_giant, res_err}, 3'b010);
      ack();
      $display("txn f2100: len=2047 giant");

      // early SOF at byte 30 of A, then B runs 70 bytes
      for (int i = 1; i <= 29; i++) send(i == 1, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0);
      chk("earlyA_valid", res_valid, 1);
      chk("earlyA_len",   res_len,   29);
      chk("earlyA_flags", {res_runt, res_giant, res_err}, 3'b101);
      chk("earlyB_busy",  busy,      1);
      res_ack = 1'b1;
      send(1'b0, 1'b0, 1'b0);
      res_ack = 1'b0;
      chk("earlyA_acked", res_valid, 0);
      for (int i = 3; i <= 70; i++) send(1'b0, i == 70, 1'b0);
      step();
      chk("earlyB_len",   res_len, 70);
      chk("earlyB_flags", {res_valid, res_runt, res_giant, res_err, ovr}, 5'b10000);
      ack();
      $display("txn early sof: A len=29 err=1, B len=70");

      // overrun: result pending, second frame completes without ack
      frame(64, 0);
      step();
      chk("ovr_first_len", res_len, 64);
      frame(10, 3);
      step();
      chk("ovr_set",      ovr,       1);
      chk("ovr_keep_len", res_len,   64);
      chk("ovr_keep_flg", {res_valid, res_runt, res_err}, 3'b100);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("ovr_clr", ovr, 0);
      // ack coincides with completion: new result replaces old
      frame(20, 0);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      chk("ackcomp_valid", res_valid, 1);
      chk("ackcomp_len",   res_len,   20);
      chk("ackcomp_ovr",   ovr,       0);
      $display("txn overrun: kept len=64, ack+completion len=20");

      // reset at byte 20 with a result still pending
      for (int i = 1; i <= 19; i++) send(i == 1, 1'b0, 1'b0);
      reset = 1'b1;
      send(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("midrst_valid", res_valid, 0);
      chk("midrst_len",   res_len,   0);
      chk("midrst_flags", {res_runt, res_giant, res_err, ovr, busy}, 5'b00000);
      frame(64, 0);
      step();
      chk("postrst_len",   res_len, 64);
      chk("postrst_flags", {res_valid, res_runt, res_giant, res_err}, 4'b1000);
      ack();
      $display("txn reset mid-frame: next len=64");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
